spike_time_decoder: RTL and testbench

Converts a bundle of temporal lines, each carrying a value as a 1->0 transition time, back into binary time-stamps. It sits at the output of the bitonic sorter stages, or of any temporal-coded column. It measures, per line, the cycle within a gamma window at which the line first falls. It also flags whether the captured times are non-decreasing by index, which is the sorter's correctness property.

---
 rtl/tnn_pkg.sv | 18 +
 rtl/spike_capture_lane.sv | 39 +++
 rtl/spike_time_decoder.sv | 114 +++++++++++
 tb/tb_spike_time_decoder.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/tnn_pkg.sv
// Shared constants, helpers and FSM state type for the temporal-coding blocks.
package tnn_pkg;

  localparam int GAMMA_DEF = 40;
  localparam int TW_DEF    = 6;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    COUNT = 2'd1,
    DONE  = 2'd2
  } tnn_state_e;

  // "Never fired" time-stamp: all ones at the given width.
  function automatic int unsigned inf_of(input int unsigned tw);
    return (32'd1 << tw) - 32'd1;
  endfunction

endpackage

// File: rtl/spike_capture_lane.sv
// One temporal line: records the counter value at the first observed fall.
module spike_capture_lane
  import tnn_pkg::*;
#(
  parameter int TW = TW_DEF
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clear,
  input  logic          en,
  input  logic [TW-1:0] t,
  input  logic          line,
  output logic [TW-1:0] time_o,
  output logic          fired_o
);

  localparam logic [TW-1:0] INF = TW'(inf_of(TW));

  logic [TW-1:0] time_q;
  logic          fired_q;

  // First-fall capture; once fired the lane ignores the line until cleared.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      time_q  <= INF;
      fired_q <= 1'b0;
    end else if (clear) begin
      time_q  <= INF;
      fired_q <= 1'b0;
    end else if (en && !fired_q && !line) begin
      time_q  <= t;
      fired_q <= 1'b1;
    end
  end

  assign time_o  = time_q;
  assign fired_o = fired_q;

endmodule

// File: rtl/spike_time_decoder.sv
// Converts N temporal lines (1->0 transition times) into binary time-stamps
// over one gamma window, and flags whether the times are non-decreasing.
module spike_time_decoder
  import tnn_pkg::*;
#(
  parameter int N     = 16,
  parameter int GAMMA = GAMMA_DEF,
  parameter int TW    = TW_DEF
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [0:N-1]    lines_in,
  input  logic            out_ready,
  output logic            busy,
  output logic            valid,
  output logic [N*TW-1:0] times_out,
  output logic [0:N-1]    fired,
  output logic            order_err
);

  localparam logic [TW-1:0] INF    = TW'(inf_of(TW));
  localparam logic [TW-1:0] T_LAST = TW'(GAMMA - 1);

  tnn_state_e    state_q;
  logic [TW-1:0] t_q;
  logic          busy_q, valid_q, order_q;

  logic                   clear, en, order_d;
  logic [N-1:0][TW-1:0]   time_w;
  logic [N-1:0][TW-1:0]   eff;
  logic [N-1:0]           fired_w;

  assign clear = (state_q == IDLE) && start;
  assign en    = (state_q == COUNT);

  for (genvar i = 0; i < N; i++) begin : g_lane
    spike_capture_lane #(.TW(TW)) u_lane (
      .clk     (clk),
      .rst     (rst),
      .clear   (clear),
      .en      (en),
      .t       (t_q),
      .line    (lines_in[i]),
      .time_o  (time_w[i]),
      .fired_o (fired_w[i])
    );
    // Time the lane will hold after this edge, so the final sample of the
    // window is already included when order_err is registered.
    assign eff[i]   = fired_w[i] ? time_w[i] : (!lines_in[i] ? t_q : INF);
    assign fired[i] = fired_w[i];
  end

  if (N > 1) begin : g_ord
    logic [N-2:0] bad;
    for (genvar i = 0; i < N - 1; i++) begin : g_cmp
      assign bad[i] = eff[i] > eff[i+1];
    end
    assign order_d = |bad;
  end else begin : g_ord1
    assign order_d = 1'b0;
  end

  // Window FSM with counter and registered status outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      t_q     <= '0;
      busy_q  <= 1'b0;
      valid_q <= 1'b0;
      order_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start) begin
            state_q <= COUNT;
            t_q     <= '0;
            busy_q  <= 1'b1;
            order_q <= 1'b0;
          end
        end
        COUNT: begin
          if (t_q == T_LAST) begin
            state_q <= DONE;
            t_q     <= '0;
            valid_q <= 1'b1;
            order_q <= order_d;
          end else begin
            t_q <= t_q + TW'(1);
          end
        end
        DONE: begin
          if (out_ready) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
            valid_q <= 1'b0;
          end
        end
        default: begin
          state_q <= IDLE;
          t_q     <= '0;
          busy_q  <= 1'b0;
          valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign busy      = busy_q;
  assign valid     = valid_q;
  assign order_err = order_q;
  assign times_out = time_w;

endmodule

// File: tb/tb_spike_time_decoder.sv
// Scoreboard bench for spike_time_decoder: stimulus pushes expected results,
// an independent monitor pops and compares whenever valid is presented.
module tb_spike_time_decoder;

  localparam int N     = 16;
  localparam int GAMMA = 40;
  localparam int TW    = 6;
  localparam int INF   = (1 << TW) - 1;

  typedef struct {
    logic [N*TW-1:0] times;
    logic [0:N-1]    fired;
    logic            oe;
  } exp_t;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic            start = 1'b0;
  logic [0:N-1]    lines_in = '1;
  logic            out_ready = 1'b0;
  logic            busy, valid, order_err;
  logic [N*TW-1:0] times_out;
  logic [0:N-1]    fired;

  spike_time_decoder #(.N(N), .GAMMA(GAMMA), .TW(TW)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .lines_in  (lines_in),
    .out_ready (out_ready),
    .busy      (busy),
    .valid     (valid),
    .times_out (times_out),
    .fired     (fired),
    .order_err (order_err)
  );

  always #5 clk = ~clk;

  int   total = 0;
  int   bad   = 0;
  exp_t q[$];
  exp_t cur;
  bit   have = 0;

  // Per-line fall time (-1 = never), return-high time, and the sampled waveform.
  int           ft[N];
  int           rt[N];
  logic [0:N-1] wave[GAMMA];
  logic [0:N-1] pre;

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s act=%0h exp=%0h", nm, act, exp);
    end
  endtask

  // Builds the waveform seen at each sample point; after returning high the
  // line may carry arbitrary noise, which must not disturb the capture.
  function automatic void build(input bit noise);
    for (int j = 0; j < GAMMA; j++)
      for (int i = 0; i < N; i++) begin
        if (ft[i] < 0 || j < ft[i]) wave[j][i] = 1'b1;
        else if (j < rt[i])         wave[j][i] = 1'b0;
        else                        wave[j][i] = noise ? 1'($urandom) : 1'b1;
      end
    for (int i = 0; i < N; i++) pre[i] = (ft[i] == 0) ? 1'b0 : 1'b1;
  endfunction

  // Reference: first sample index at which each line is low, else INF.
  function automatic exp_t model();
    exp_t e;
    int   tm[N];
    for (int i = 0; i < N; i++) begin
      tm[i] = INF;
      for (int j = GAMMA - 1; j >= 0; j--) if (wave[j][i] == 1'b0) tm[i] = j;
      e.fired[i] = (tm[i] != INF);
      e.times[i*TW +: TW] = TW'(tm[i]);
    end
    e.oe = 1'b0;
    for (int i = 0; i < N - 1; i++) if (tm[i] > tm[i+1]) e.oe = 1'b1;
    return e;
  endfunction

  // Full window: start edge, GAMMA samples, then `hold` cycles of backpressure.
  task automatic run_window(input int hold, input bit pulse);
    q.push_back(model());
    lines_in = pre;
    start    = 1'b1;
    @(posedge clk); #1;
    for (int j = 0; j < GAMMA; j++) begin
      lines_in = wave[j];
      start    = pulse ? 1'($urandom) : 1'b0;
      if (j == GAMMA - 1) begin
        chk("valid_before_last", {127'd0, valid}, 128'd0);
        chk("busy_in_count", {127'd0, busy}, 128'd1);
      end
      @(posedge clk); #1;
    end
    chk("valid_at_gamma", {127'd0, valid}, 128'd1);
    out_ready = 1'b0;
    for (int h = 0; h < hold; h++) begin
      start    = pulse ? 1'($urandom) : 1'b0;
      lines_in = N'($urandom);
      @(posedge clk); #1;
      chk("valid_hold", {127'd0, valid}, 128'd1);
    end
    start     = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk("valid_after_hs", {127'd0, valid}, 128'd0);
    chk("busy_after_hs", {127'd0, busy}, 128'd0);
  endtask

  function automatic void clear_ft();
    for (int i = 0; i < N; i++) begin
      ft[i] = -1;
      rt[i] = GAMMA + 10;
    end
  endfunction

  // Monitor: pops on each new valid result, checks every cycle it is held.
  always @(negedge clk) begin
    if (rst || !valid) begin
      have = 0;
    end else begin
      if (!have) begin
        if (q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL sb_unexpected act=valid exp=no_result");
        end else begin
          cur  = q.pop_front();
          have = 1;
        end
      end
      if (have) begin
        chk("times", 128'(times_out), 128'(cur.times));
        chk("fired", 128'(fired), 128'(cur.fired));
        chk("order_err", {127'd0, order_err}, {127'd0, cur.oe});
        chk("busy_done", {127'd0, busy}, 128'd1);
      end
    end
  end

  initial begin
    logic [N*TW-1:0] all_inf;
    all_inf = '1;

    // Reset held for three cycles, lines idle high.
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", {127'd0, busy}, 128'd0);
    chk("rst_valid", {127'd0, valid}, 128'd0);
    chk("rst_fired", 128'(fired), 128'd0);
    chk("rst_times", 128'(times_out), 128'(all_inf));
    chk("rst_order", {127'd0, order_err}, 128'd0);
    rst = 1'b0;
    @(posedge clk); #1;

    // Sorter mirror: line1 returns high at 9, capture stays 7.
    clear_ft(); ft[0] = 5; ft[1] = 7; rt[1] = 9;
    build(1'b0); run_window(0, 1'b0);

    // Unfired line ahead of a fired one.
    clear_ft(); ft[1] = 3;
    build(1'b0); run_window(0, 1'b0);

    // All lines low before the window; backpressure with start pulses.
    clear_ft(); for (int i = 0; i < N; i++) ft[i] = 0;
    build(1'b0); run_window(10, 1'b1);

    // Reset in the middle of a window.
    clear_ft(); ft[0] = 12;
    build(1'b0);
    lines_in = pre; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    for (int j = 0; j <= 20; j++) begin
      lines_in = wave[j];
      @(posedge clk); #1;
    end
    #1 rst = 1'b1;
    #1;
    chk("mid_rst_busy", {127'd0, busy}, 128'd0);
    chk("mid_rst_valid", {127'd0, valid}, 128'd0);
    chk("mid_rst_fired", 128'(fired), 128'd0);
    chk("mid_rst_times", 128'(times_out), 128'(all_inf));
    chk("mid_rst_order", {127'd0, order_err}, 128'd0);
    @(posedge clk); #1;
    rst = 1'b0; lines_in = '1;
    repeat (3) @(posedge clk);
    #1;
    chk("no_auto_restart", {127'd0, busy}, 128'd0);

    clear_ft(); ft[0] = 2;
    build(1'b0); run_window(1, 1'b0);

    // Full ordered window, then two lines swapped.
    clear_ft(); for (int i = 0; i < N; i++) ft[i] = 2 * i;
    build(1'b0); run_window(0, 1'b0);
    clear_ft(); for (int i = 0; i < N; i++) ft[i] = 2 * i;
    ft[3] = 8; ft[4] = 6;
    build(1'b0); run_window(2, 1'b1);

    // Randomized windows; half with sorted fall times.
    for (int w = 0; w < 30; w++) begin
      for (int i = 0; i < N; i++) begin
        ft[i] = ($urandom_range(0, 7) == 0) ? -1 : int'($urandom_range(0, GAMMA + 5));
        rt[i] = GAMMA + 10;
      end
      if (w % 2 == 0) ft.sort();
      for (int i = 0; i < N; i++) if (ft[i] >= 0) rt[i] = ft[i] + int'($urandom_range(1, 12));
      build(1'b1);
      run_window(int'($urandom_range(0, 4)), 1'($urandom));
    end

    repeat (3) @(posedge clk);
    #1;
    chk("sb_drained", 128'(q.size()), 128'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Global time limit so the run always terminates.
  initial begin
    #1_000_000;
    $display("FAIL timeout act=running exp=finished");
    $fatal(1, "timeout");
  end

endmodule
